// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath, with a memory wait-state timeout.
// Optional retired-instruction counter: define MULTICYCLE_CONTROL_INSTR_COUNT_EN.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             wait_st_s;
  logic             timeout_hit_s;
  logic             timeout_pulse_s;

  assign timeout_hit_s = (TIMEOUT_V != {CNT_W{1'b0}}) && (wait_cnt_r == TIMEOUT_V) && !mem_ready;
  assign state         = state_r;
  assign mem_timeout   = timeout_pulse_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and Moore output decode; only FETCH lets mem_ready reach the write enables
  always_comb begin
    next_s          = state_r;
    PCWrite         = 1'b0;
    PCWriteCond     = 1'b0;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    IRWrite         = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    RegWrite        = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    ALUOp           = 2'b00;
    PCSource        = 2'b00;
    illegal_op      = 1'b0;
    wait_st_s       = 1'b0;
    timeout_pulse_s = 1'b0;
    case (state_r)
      S_IDLE: next_s = S_FETCH;
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        wait_st_s = 1'b1;
        if (mem_ready) begin
          next_s = S_DECODE;
        end else if (timeout_hit_s) begin
          timeout_pulse_s = 1'b1;
          next_s          = S_FETCH;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_EXEC;
          OP_BEQ:       next_s = S_BRANCH;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            next_s     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW) begin
          next_s = S_MEMRD;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        wait_st_s = 1'b1;
        if (mem_ready) begin
          next_s = S_MEMWB;
        end else if (timeout_hit_s) begin
          timeout_pulse_s = 1'b1;
          next_s          = S_FETCH;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        next_s   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        wait_st_s = 1'b1;
        if (mem_ready) begin
          next_s = S_FETCH;
        end else if (timeout_hit_s) begin
          timeout_pulse_s = 1'b1;
          next_s          = S_FETCH;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        next_s  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        next_s   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        next_s      = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next_s  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        next_s   = S_FETCH;
      end
      default: next_s = S_FETCH;
    endcase
  end

  // Wait counter: a timeout in FETCH does not change state, so it clears explicitly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((next_s != state_r) || timeout_pulse_s) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (wait_st_s && !mem_ready && (wait_cnt_r != TIMEOUT_V)) begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  logic [31:0] instr_count_r;
  logic        retire_s;

  assign retire_s = (next_s == S_FETCH) && !timeout_pulse_s &&
                    (state_r inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});
  assign instr_count = instr_count_r;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count_r <= 32'd0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + 32'd1;
    end else begin
      instr_count_r <= instr_count_r;
    end
  end
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one linear initial block, immediate assertions per check.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal_op, mem_timeout;
  logic [31:0] instr_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [21:0] obs_ctrl;
  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, state, illegal_op, mem_timeout};

  // Expected control word for a state, straight from the per-state output table
  function automatic logic [21:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic ill, input logic to);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = 10'd0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd1:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  srcb = 2'b11;
      4'd3:  begin srca = 1'b1; srcb = 2'b10; end
      4'd4:  begin mrd = 1'b1; iord = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mwr = 1'b1; iord = 1'b1; end
      4'd7:  begin srca = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rdst = 1'b1; end
      4'd9:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd10: begin srca = 1'b1; srcb = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin pcw = 1'b1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, st, ill, to};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] st, input logic ill, input logic to);
    #1;
    chk(tag, 32'(obs_ctrl), 32'(exp_ctrl(st, mem_ready, ill, to)));
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
    chk({tag, "_cnt"}, instr_count, exp_cnt);
`else
    chk({tag, "_cnt"}, instr_count, 32'd0);
`endif
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic ill, input logic to);
    check_now(tag, st, ill, to);
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    exp_cnt   = 32'd0;

    // reset held three cycles, R-type sequence 0,1,2,7,8,1
    step("rst0", 4'd0, 1'b0, 1'b0);
    step("rst1", 4'd0, 1'b0, 1'b0);
    step("rst2", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step("r_idle", 4'd0, 1'b0, 1'b0);
    step("r_fetch", 4'd1, 1'b0, 1'b0);
    step("r_dec", 4'd2, 1'b0, 1'b0);
    step("r_exec", 4'd7, 1'b0, 1'b0);
    step("r_aluwb", 4'd8, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 32'd1;

    // lw with two wait cycles in MEMRD
    opcode = 6'b100011;
    step("lw_fetch", 4'd1, 1'b0, 1'b0);
    step("lw_dec", 4'd2, 1'b0, 1'b0);
    step("lw_madr", 4'd3, 1'b0, 1'b0);
    mem_ready = 1'b0;
    step("lw_mrd_w1", 4'd4, 1'b0, 1'b0);
    step("lw_mrd_w2", 4'd4, 1'b0, 1'b0);
    mem_ready = 1'b1;
    step("lw_mrd", 4'd4, 1'b0, 1'b0);
    step("lw_mwb", 4'd5, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 32'd1;

    // beq then j
    opcode = 6'b000100;
    step("beq_fetch", 4'd1, 1'b0, 1'b0);
    step("beq_dec", 4'd2, 1'b0, 1'b0);
    step("beq_br", 4'd9, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 32'd1;
    opcode = 6'b000010;
    step("j_fetch", 4'd1, 1'b0, 1'b0);
    step("j_dec", 4'd2, 1'b0, 1'b0);
    step("j_jump", 4'd12, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 32'd1;

    // illegal opcode: pulse in DECODE, back to FETCH, not counted
    opcode = 6'b111111;
    step("ill_fetch", 4'd1, 1'b0, 1'b0);
    step("ill_dec", 4'd2, 1'b1, 1'b0);

    // sw with memory stuck: timeout on the 5th MEMWR cycle
    opcode = 6'b101011;
    step("sw_fetch", 4'd1, 1'b0, 1'b0);
    step("sw_dec", 4'd2, 1'b0, 1'b0);
    step("sw_madr", 4'd3, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("sw_wait", 4'd6, 1'b0, 1'b0);
    step("sw_tmo", 4'd6, 1'b0, 1'b1);

    // FETCH times out and re-enters with a cleared counter
    for (int i = 0; i < 4; i++) step("f_wait_a", 4'd1, 1'b0, 1'b0);
    step("f_tmo", 4'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("f_wait_b", 4'd1, 1'b0, 1'b0);
    // ready coincides with the timeout count: ready wins, no pulse
    mem_ready = 1'b1;
    opcode    = 6'b001000;
    step("f_ready_wins", 4'd1, 1'b0, 1'b0);
    step("addi_dec", 4'd2, 1'b0, 1'b0);
    step("addi_ex", 4'd10, 1'b0, 1'b0);
    step("addi_wb", 4'd11, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 32'd1;

    // reset asserted in MEMWB
    opcode = 6'b100011;
    step("rl_fetch", 4'd1, 1'b0, 1'b0);
    step("rl_dec", 4'd2, 1'b0, 1'b0);
    step("rl_madr", 4'd3, 1'b0, 1'b0);
    step("rl_mrd", 4'd4, 1'b0, 1'b0);
    check_now("rl_mwb", 4'd5, 1'b0, 1'b0);
    reset   = 1'b1;
    exp_cnt = 32'd0;
    check_now("rl_async_rst", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step("rl_idle", 4'd0, 1'b0, 1'b0);
    step("rl_fetch2", 4'd1, 1'b0, 1'b0);
    step("rl_dec2", 4'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
